jump_redirect: RTL and testbench
================================

Name: jump_redirect

Overview:
- Consumer end of the jump-prediction interface; sits between the jump predictor and the IF-stage PC register.
- Records each prediction made in ID in a small in-flight queue.
- Compares each record with the real outcome when the jump resolves in MEM.
- Drives next-PC selection and the IF/ID/EX flushes for both predicted-taken redirects and mispredict recovery.

Parameters:
- QDEPTH, 4, in-flight prediction queue depth (power of two, at least 2).
- QUIET, 2, cycles after a recovery during which pred_enable is held low.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  global pipeline stall; freezes this block except reset
- pc_if  in  16  current IF PC
- id_jump  in  1  a jump-class instruction is in ID
- id_pcinc  in  16  fall-through address (PC+1) of the ID instruction
- pred_taken  in  1  predictor says taken for the ID instruction
- pred_target  in  16  predicted target
- mem_resolve  in  1  a jump-class instruction is in MEM this cycle
- mem_taken  in  1  real outcome
- mem_target  in  16  real target (ALU result)
- pc_next  out  16  value to load into the PC
- pc_we  out  1  PC write enable
- flush_if  out  1  squash the IF instruction
- flush_id  out  1  squash the ID instruction
- flush_ex  out  1  squash the EX instruction
- pred_enable  out  1  predictor may issue predictions
- q_count  out  3  queue occupancy
- q_error  out  1  sticky: overflow or underflow seen
- resolve_cnt  out  16  saturating count of resolved jumps
- miss_cnt  out  16  saturating count of mispredicts

Behaviour:
- Reset values: queue empty, q_count=0, q_error=0, both counters 0, quiet counter 0, pred_enable=1, flushes 0.
- pc_we and pc_next are combinational. Registered state: queue, counters, quiet counter.
- Stall high:
  - pc_we=0, flushes 0.
  - No push, no pop, counters and quiet timer hold.
- Priority in one unstalled cycle: reset > MEM recovery > ID predicted redirect > sequential.
- Push: on id_jump & !stall & !recover, push {pred_taken & pred_enable, pred_target, id_pcinc}.
- Pop: on mem_resolve & !stall, pop the head entry, then compare.
  - recover = (head.taken != mem_taken) | (head.taken & mem_taken & head.target != mem_target).
  - resolve_cnt increments on every pop. miss_cnt increments on recover. Both saturate at 16'hFFFF.
- Recovery cycle:
  - pc_next = mem_taken ? mem_target : head.pcinc; pc_we=1.
  - flush_if=flush_id=flush_ex=1.
  - Entire queue cleared, including a same-cycle push, which is dropped.
  - Quiet counter loads QUIET.
- ID predicted redirect (no recovery):
  - Applies when id_jump & pred_taken & pred_enable.
  - pc_next=pred_target, pc_we=1, flush_if=1 (one-bubble penalty). Entry is pushed.
- Sequential: pc_next=pc_if+1 (mod 2^16, wraps FFFF->0000), pc_we=1.
- pred_enable = (quiet counter == 0). Quiet counter decrements each unstalled cycle while nonzero.
- Same-cycle push and pop without recovery: q_count unchanged; the head advances and the new entry is written at the tail.
- Overflow (push when full): push ignored, q_error set.
- Underflow (pop when empty): head treated as {taken=0, target=0, pcinc=pc_if}, q_error set, comparison proceeds.
- Queue is a circular buffer. Read/write pointers wrap at QDEPTH.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef pred_entry_t {taken; target[15:0]; pcinc[15:0]}
  - constant PC_W=16
- One sub-module, pred_fifo: parameterised circular FIFO of pred_entry_t with push, pop, clear, count, full, empty.
- Recovery and PC-select logic stay in jump_redirect.

Test Plan:
- Reset, then 5 unstalled cycles with pc_if=0x0010..0x0014 and no jumps -> pc_next=pc_if+1 each cycle, no flush, q_count=0.
- ID push {pred_taken=1, target=0x0200, pcinc=0x0041}; two cycles later resolve with mem_taken=1, target=0x0200:
  - push cycle -> pc_next=0x0200, flush_if=1 only.
  - resolve cycle -> no recovery; resolve_cnt=1, miss_cnt=0.
- Predicted not taken, pcinc=0x0051; resolve mem_taken=1, target=0x0300 -> pc_next=0x0300, all three flushes, q_count=0, pred_enable low for 2 cycles, miss_cnt=1.
- Predicted taken to 0x0400, pcinc=0x0061; resolve mem_taken=0 -> pc_next=0x0061, flushes.
- Predicted taken to 0x0400; resolve taken to 0x0404 -> pc_next=0x0404.
- Recovery in the same cycle as an ID push -> push dropped, q_count=0.
- Hold stall during a resolve -> nothing pops until stall falls.
- Five pushes with no pops -> q_count=4, q_error=1.
- Resolve on an empty queue -> q_error=1.
- pc_if=0xFFFF -> pc_next=0x0000.
- Force miss_cnt to 0xFFFF -> it stays at 0xFFFF after a further miss.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the jump-prediction slice of the pipeline.
//   PC_W         : program counter width
//   pred_entry_t : one in-flight prediction record as captured in ID
//                  (predicted direction, predicted target, fall-through PC)
package cpu_pkg;

    localparam int PC_W = 16;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] pcinc;
    } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo
// Circular FIFO of pred_entry_t records used to carry predictions from ID
// to MEM.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   push_i / wdata_i    : append wdata_i at the tail
//   pop_i               : advance the head
//   clear_i             : drop every entry (wins over push and pop)
//   rdata_o             : current head entry (meaningless while empty)
//   count_o             : occupancy, 0..DEPTH
//   full_o / empty_o    : occupancy flags
// A push while full is accepted only when a pop frees a slot in the same
// cycle; a pop while empty is ignored.
module pred_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  pred_entry_t   wdata_i,
    output pred_entry_t   rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    pred_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointers are AW bits wide, so they wrap at DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (!reset && !clear_i && push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/jump_redirect.sv
// jump_redirect
// Consumer side of the jump predictor. Records every ID-stage prediction,
// checks it against the real outcome when the jump reaches MEM, and selects
// the next PC plus the IF/ID/EX squashes.
// Ports:
//   clk, reset, stall          : clock, sync reset, global pipeline freeze
//   pc_if                      : PC of the instruction in IF
//   id_jump, id_pcinc          : jump in ID and its fall-through address
//   pred_taken, pred_target    : predictor output for the ID jump
//   mem_resolve, mem_taken,
//   mem_target                 : real outcome of the jump in MEM
//   pc_next, pc_we             : PC register load value / enable
//   flush_if, flush_id,
//   flush_ex                   : squash requests
//   pred_enable                : predictor allowed to predict taken
//   q_count, q_error           : queue occupancy, sticky over/underflow
//   resolve_cnt, miss_cnt      : saturating statistics
module jump_redirect
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int QUIET  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [15:0] pc_if,
    input  logic        id_jump,
    input  logic [15:0] id_pcinc,
    input  logic        pred_taken,
    input  logic [15:0] pred_target,
    input  logic        mem_resolve,
    input  logic        mem_taken,
    input  logic [15:0] mem_target,
    output logic [15:0] pc_next,
    output logic        pc_we,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        pred_enable,
    output logic [2:0]  q_count,
    output logic        q_error,
    output logic [15:0] resolve_cnt,
    output logic [15:0] miss_cnt
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int QW = (QUIET < 1) ? 1 : $clog2(QUIET + 1);

    pred_entry_t   fifo_wdata;
    pred_entry_t   fifo_rdata;
    pred_entry_t   head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_req;
    logic          push_req;
    logic          recover;
    logic          pred_redirect;
    logic [PC_W-1:0] pc_inc;

    logic [QW-1:0] quiet_q, quiet_d;
    logic [15:0]   resolve_cnt_q, resolve_cnt_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;
    logic          q_error_q, q_error_d;

    assign pred_enable = (quiet_q == '0);
    assign pc_inc      = pc_if + 16'd1;

    assign fifo_wdata.taken  = pred_taken & pred_enable;
    assign fifo_wdata.target = pred_target;
    assign fifo_wdata.pcinc  = id_pcinc;

    // An empty queue stands in a not-taken record whose fall-through is
    // the current IF PC, so an unexpected resolve still gets compared.
    always_comb begin
        if (fifo_empty) begin
            head.taken  = 1'b0;
            head.target = '0;
            head.pcinc  = pc_if;
        end else begin
            head = fifo_rdata;
        end
    end

    assign pop_req  = mem_resolve & ~stall & ~reset;
    assign recover  = pop_req &
                      ((head.taken != mem_taken) |
                       (head.taken & mem_taken & (head.target != mem_target)));
    // A push in the same cycle as a recovery belongs to the wrong path.
    assign push_req = id_jump & ~stall & ~reset & ~recover;
    assign pred_redirect = id_jump & pred_taken & pred_enable;

    pred_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .clear_i (recover),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-PC selection: recovery beats the ID redirect, which beats
    // sequential fetch. Reset and stall hold the PC.
    always_comb begin
        pc_next  = pc_inc;
        pc_we    = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (!reset && !stall) begin
            pc_we = 1'b1;
            if (recover) begin
                pc_next  = mem_taken ? mem_target : head.pcinc;
                flush_if = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (pred_redirect) begin
                pc_next  = pred_target;
                flush_if = 1'b1;
            end
        end
    end

    // Statistics, error flag and the post-recovery quiet window.
    always_comb begin
        resolve_cnt_d = resolve_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        quiet_d       = quiet_q;
        q_error_d     = q_error_q;
        if (pop_req && resolve_cnt_q != 16'hFFFF) resolve_cnt_d = resolve_cnt_q + 16'd1;
        if (recover && miss_cnt_q != 16'hFFFF)    miss_cnt_d    = miss_cnt_q + 16'd1;
        if (!stall) begin
            if (recover)              quiet_d = QW'(QUIET);
            else if (quiet_q != '0)   quiet_d = quiet_q - 1'b1;
        end
        if ((push_req && fifo_full && !(pop_req && !fifo_empty)) ||
            (pop_req && fifo_empty)) begin
            q_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resolve_cnt_q <= '0;
            miss_cnt_q    <= '0;
            quiet_q       <= '0;
            q_error_q     <= 1'b0;
        end else begin
            resolve_cnt_q <= resolve_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            quiet_q       <= quiet_d;
            q_error_q     <= q_error_d;
        end
    end

    assign q_count     = 3'(fifo_count);
    assign q_error     = q_error_q;
    assign resolve_cnt = resolve_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_jump_redirect.sv
// tb_jump_redirect
// Scenario-driven bench for jump_redirect. Predictions are pushed into a
// scoreboard queue as they are driven in ID and popped when the matching
// resolve is driven in MEM; the expected PC select, flushes and statistics
// come from that queue and a small model of the quiet window and counters.
module tb_jump_redirect;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] pc_if = '0;
    logic        id_jump = 1'b0;
    logic [15:0] id_pcinc = '0;
    logic        pred_taken = 1'b0;
    logic [15:0] pred_target = '0;
    logic        mem_resolve = 1'b0;
    logic        mem_taken = 1'b0;
    logic [15:0] mem_target = '0;
    logic [15:0] pc_next;
    logic        pc_we, flush_if, flush_id, flush_ex, pred_enable, q_error;
    logic [2:0]  q_count;
    logic [15:0] resolve_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard and model state (state after the most recent driven edge).
    pred_entry_t sbq[$];
    int          m_quiet;
    logic [15:0] m_res, m_miss;
    logic        m_err;
    // Registered values the DUT should show during the current cycle.
    int          r_count;
    logic [15:0] r_res, r_miss;
    logic        r_err;
    // Expected combinational outputs for the current cycle.
    logic [15:0] e_pc;
    logic        e_we, e_fif, e_fid, e_fex, e_pen;

    jump_redirect #(.QDEPTH(4), .QUIET(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_if(pc_if),
        .id_jump(id_jump), .id_pcinc(id_pcinc), .pred_taken(pred_taken),
        .pred_target(pred_target), .mem_resolve(mem_resolve),
        .mem_taken(mem_taken), .mem_target(mem_target), .pc_next(pc_next),
        .pc_we(pc_we), .flush_if(flush_if), .flush_id(flush_id),
        .flush_ex(flush_ex), .pred_enable(pred_enable), .q_count(q_count),
        .q_error(q_error), .resolve_cnt(resolve_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        sbq.delete();
        m_quiet = 0;
        m_res   = '0;
        m_miss  = '0;
        m_err   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; stall = 1'b0; id_jump = 1'b0; mem_resolve = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // Drives one unreset cycle, advances the model, returns at mid-cycle.
    task automatic drive(input logic st, input logic [15:0] pc,
                         input logic idj, input logic [15:0] inc,
                         input logic pt, input logic [15:0] ptg,
                         input logic mr, input logic mt, input logic [15:0] mtg);
        pred_entry_t head;
        logic rec;
        pred_entry_t ent;
        @(posedge clk); #1;
        stall = st; pc_if = pc; id_jump = idj; id_pcinc = inc;
        pred_taken = pt; pred_target = ptg;
        mem_resolve = mr; mem_taken = mt; mem_target = mtg;
        r_count = sbq.size(); r_res = m_res; r_miss = m_miss; r_err = m_err;
        e_pen = (m_quiet == 0);
        head.taken = 1'b0; head.target = '0; head.pcinc = pc;
        rec = 1'b0;
        if (mr && !st) begin
            if (sbq.size() > 0) head = sbq.pop_front();
            else m_err = 1'b1;
            rec = (head.taken != mt) || (head.taken && mt && head.target != mtg);
            if (m_res != 16'hFFFF) m_res = m_res + 16'd1;
            if (rec && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
        end
        if (rec) begin
            sbq.delete();
        end else if (idj && !st) begin
            if (sbq.size() < 4) begin
                ent.taken = pt && e_pen; ent.target = ptg; ent.pcinc = inc;
                sbq.push_back(ent);
            end else begin
                m_err = 1'b1;
            end
        end
        if (!st) begin
            if (rec) m_quiet = 2;
            else if (m_quiet > 0) m_quiet = m_quiet - 1;
        end
        e_pc = pc + 16'd1; e_we = !st; e_fif = 1'b0; e_fid = 1'b0; e_fex = 1'b0;
        if (!st) begin
            if (rec) begin
                e_pc = mt ? mtg : head.pcinc;
                e_fif = 1'b1; e_fid = 1'b1; e_fex = 1'b1;
            end else if (idj && pt && e_pen) begin
                e_pc = ptg; e_fif = 1'b1;
            end
        end
        #4;
    endtask

    task automatic idle(input logic [15:0] pc);
        drive(1'b0, pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        n_tests++;
        if ({q_count, q_error, resolve_cnt, miss_cnt, pred_enable, flush_if, flush_id, flush_ex}
            !== {3'd0, 1'b0, 16'h0, 16'h0, 1'b1, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got cnt=%0d err=%b res=%h miss=%h pen=%b fl=%b%b%b, want 0 0 0000 0000 1 000",
                     q_count, q_error, resolve_cnt, miss_cnt, pred_enable, flush_if, flush_id, flush_ex);
        end
        @(posedge clk); #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            idle(16'h0010 + 16'(i));
            n_tests++;
            if ({pc_we, pc_next, flush_if, flush_id, flush_ex, q_count}
                !== {1'b1, 16'h0011 + 16'(i), 3'b000, 3'd0}) begin
                n_fail++;
                $display("[TB] FAIL seq_%0d: got we=%b pc=%h fl=%b%b%b cnt=%0d, want pc=%h no flush cnt=0",
                         i, pc_we, pc_next, flush_if, flush_id, flush_ex, q_count, 16'h0011 + 16'(i));
            end
        end
    endtask

    task automatic test_predict_hit();
        drive(1'b0, 16'h0040, 1'b1, 16'h0041, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {1'b1, 16'h0200, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL hit_push: got we=%b pc=%h fl=%b%b%b, want 1 0200 100",
                     pc_we, pc_next, flush_if, flush_id, flush_ex);
        end
        idle(16'h0200);
        drive(1'b0, 16'h0201, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0200);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {e_we, e_pc, e_fif, e_fid, e_fex}) begin
            n_fail++;
            $display("[TB] FAIL hit_resolve: got we=%b pc=%h fl=%b%b%b, want %b %h %b%b%b",
                     pc_we, pc_next, flush_if, flush_id, flush_ex, e_we, e_pc, e_fif, e_fid, e_fex);
        end
        idle(16'h0202);
        n_tests++;
        if ({resolve_cnt, miss_cnt, q_count} !== {16'd1, 16'd0, 3'd0}) begin
            n_fail++;
            $display("[TB] FAIL hit_counts: got res=%0d miss=%0d cnt=%0d, want 1 0 0",
                     resolve_cnt, miss_cnt, q_count);
        end
    endtask

    task automatic test_mispredict_nt();
        drive(1'b0, 16'h0050, 1'b1, 16'h0051, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
        idle(16'h0051);
        drive(1'b0, 16'h0052, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0300);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {1'b1, 16'h0300, 3'b111}) begin
            n_fail++;
            $display("[TB] FAIL nt_recover: got we=%b pc=%h fl=%b%b%b, want 1 0300 111",
                     pc_we, pc_next, flush_if, flush_id, flush_ex);
        end
        for (int i = 0; i < 3; i++) begin
            idle(16'h0300 + 16'(i));
            n_tests++;
            if ({pred_enable, q_count, miss_cnt} !== {e_pen, 3'(r_count), r_miss}) begin
                n_fail++;
                $display("[TB] FAIL nt_quiet_%0d: got pen=%b cnt=%0d miss=%0d, want %b %0d %0d",
                         i, pred_enable, q_count, miss_cnt, e_pen, r_count, r_miss);
            end
        end
    endtask

    task automatic test_taken_not();
        drive(1'b0, 16'h0060, 1'b1, 16'h0061, 1'b1, 16'h0400, 1'b0, 1'b0, 16'h0);
        idle(16'h0400);
        drive(1'b0, 16'h0401, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {1'b1, 16'h0061, 3'b111}) begin
            n_fail++;
            $display("[TB] FAIL tn_recover: got we=%b pc=%h fl=%b%b%b, want 1 0061 111",
                     pc_we, pc_next, flush_if, flush_id, flush_ex);
        end
        repeat (3) idle(16'h0070);
    endtask

    task automatic test_wrong_target();
        drive(1'b0, 16'h0060, 1'b1, 16'h0061, 1'b1, 16'h0400, 1'b0, 1'b0, 16'h0);
        idle(16'h0400);
        drive(1'b0, 16'h0401, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0404);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {1'b1, 16'h0404, 3'b111}) begin
            n_fail++;
            $display("[TB] FAIL wt_recover: got we=%b pc=%h fl=%b%b%b, want 1 0404 111",
                     pc_we, pc_next, flush_if, flush_id, flush_ex);
        end
        repeat (3) idle(16'h0405);
    endtask

    task automatic test_recover_push();
        drive(1'b0, 16'h006F, 1'b1, 16'h0070, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 16'h0070, 1'b1, 16'h0071, 1'b1, 16'h0600, 1'b1, 1'b1, 16'h0500);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {1'b1, 16'h0500, 3'b111}) begin
            n_fail++;
            $display("[TB] FAIL rp_recover: got we=%b pc=%h fl=%b%b%b, want 1 0500 111",
                     pc_we, pc_next, flush_if, flush_id, flush_ex);
        end
        idle(16'h0500);
        n_tests++;
        if (q_count !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL rp_dropped: got cnt=%0d, want 0", q_count);
        end
        repeat (2) idle(16'h0501);
    endtask

    task automatic test_stall();
        drive(1'b0, 16'h007F, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0080, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
            n_tests++;
            if ({pc_we, flush_if, flush_id, flush_ex, q_count, resolve_cnt}
                !== {4'b0000, 3'd1, r_res}) begin
                n_fail++;
                $display("[TB] FAIL stall_hold_%0d: got we=%b fl=%b%b%b cnt=%0d res=%0d, want 0 000 1 %0d",
                         i, pc_we, flush_if, flush_id, flush_ex, q_count, resolve_cnt, r_res);
            end
        end
        drive(1'b0, 16'h0080, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        idle(16'h0081);
        n_tests++;
        if ({q_count, resolve_cnt} !== {3'd0, r_res}) begin
            n_fail++;
            $display("[TB] FAIL stall_release: got cnt=%0d res=%0d, want 0 %0d",
                     q_count, resolve_cnt, r_res);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1'b0, 16'h0090, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_tests++;
        if ({pc_we, pc_next, flush_if, flush_id, flush_ex} !== {1'b1, 16'h0091, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL uf_pc: got we=%b pc=%h fl=%b%b%b, want 1 0091 000",
                     pc_we, pc_next, flush_if, flush_id, flush_ex);
        end
        idle(16'h0091);
        n_tests++;
        if ({q_error, q_count, resolve_cnt} !== {1'b1, 3'd0, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL uf_error: got err=%b cnt=%0d res=%0d, want 1 0 1",
                     q_error, q_count, resolve_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h00A0 + 16'(i), 1'b1, 16'h00A1 + 16'(i), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
            n_tests++;
            if ({q_count, q_error} !== {3'(r_count), r_err}) begin
                n_fail++;
                $display("[TB] FAIL of_fill_%0d: got cnt=%0d err=%b, want %0d %b",
                         i, q_count, q_error, r_count, r_err);
            end
        end
        idle(16'h00B0);
        n_tests++;
        if ({q_count, q_error} !== {3'd4, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL of_full: got cnt=%0d err=%b, want 4 1", q_count, q_error);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        idle(16'hFFFF);
        n_tests++;
        if ({pc_we, pc_next} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("[TB] FAIL pc_wrap: got we=%b pc=%h, want 1 0000", pc_we, pc_next);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010);
        end
        idle(16'h0010);
        n_tests++;
        if ({miss_cnt, resolve_cnt} !== {16'hFFFF, 16'hFFFF}) begin
            n_fail++;
            $display("[TB] FAIL sat_reach: got miss=%h res=%h, want FFFF FFFF", miss_cnt, resolve_cnt);
        end
        drive(1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010);
        n_tests++;
        if ({pc_next, flush_ex} !== {16'h0010, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL sat_recover: got pc=%h fex=%b, want 0010 1", pc_next, flush_ex);
        end
        idle(16'h0010);
        n_tests++;
        if ({miss_cnt, resolve_cnt} !== {16'hFFFF, 16'hFFFF}) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: got miss=%h res=%h, want FFFF FFFF", miss_cnt, resolve_cnt);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_sequential();
        test_predict_hit();
        test_mispredict_nt();
        test_taken_not();
        test_wrong_target();
        test_recover_push();
        test_stall();
        test_underflow();
        test_overflow();
        test_wrap();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
